// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: entry struct, FSM state enum and widths.
// Latency: n/a (types only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int FUNC_W  = 4;

  // One buffered ALU result with its writeback tags.
  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic [FUNC_W-1:0]  func;
    logic [RADDR_W-1:0] rd;
    logic               wen;
    logic               zero;
  } alu_res_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } res_state_t;

  // Builds an entry from raw ALU outputs. The write-enable is qualified here
  // so that x0 can never be written, and the zero flag is derived once.
  function automatic alu_res_t res_capture(
    input logic [DATA_W-1:0]  result,
    input logic [FUNC_W-1:0]  func,
    input logic [RADDR_W-1:0] rd,
    input logic               wen
  );
    alu_res_t e;
    e.result = result;
    e.func   = func;
    e.rd     = rd;
    e.wen    = wen & (rd != '0);
    e.zero   = (result == '0);
    return e;
  endfunction

endpackage

// File: rtl/alu_res_entry.sv
// Single enable-loaded storage slot of type alu_res_t (used as head and tail).
// Latency: 1 cycle from i_ld to o_q.
// Backpressure: none; holds its value whenever i_ld is low.
//
// Ports:
//   clock   - system clock, rising edge
//   n_reset - asynchronous active-low reset, clears the slot
//   i_ld    - load enable
//   i_d     - entry to load
//   o_q     - stored entry
module alu_res_entry
  import alu_pkg::*;
(
  input  logic     clock,
  input  logic     n_reset,
  input  logic     i_ld,
  input  alu_res_t i_d,
  output alu_res_t o_q
);

  alu_res_t r_q;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback two-entry skid buffer: captures ALU results, tags, zero flag.
// Latency: 1 cycle in_* -> out_*, all outputs registered, no in->out comb path.
// Backpressure: in_ready drops only when both entries are occupied (state-only).
//
// Ports:
//   clock, n_reset           - clock (rising edge), async active-low reset
//   in_valid/in_ready        - upstream handshake
//   in_result/func/rd/wen    - ALU result and writeback tags
//   out_valid/out_ready      - writeback handshake on the head entry
//   out_result/rd/wen/zero/func - head entry fields (wen already x0-qualified)
//   fwd_valid/fwd_rd/fwd_data - forwarding of the youngest writing entry,
//                               present only when ALU_RES_FWD_EN is defined
//
// N and RADDR must equal alu_pkg::DATA_W / RADDR_W, since the entry struct
// fixes its field widths in the package.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int RADDR = RADDR_W
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_result,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [RADDR-1:0]  in_rd,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_result,
  output logic [RADDR-1:0]  out_rd,
  output logic              out_wen,
  output logic              out_zero,
  output logic [FUNC_W-1:0] out_func
`ifdef ALU_RES_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RADDR-1:0]  fwd_rd,
  output logic [N-1:0]      fwd_data
`endif
);

  res_state_t r_state;
  res_state_t w_state_nxt;
  logic       r_in_ready;
  logic       w_push;
  logic       w_pop;
  logic       w_head_ld;
  logic       w_tail_ld;
  alu_res_t   w_in_ent;
  alu_res_t   w_head_d;
  alu_res_t   w_head_q;
  alu_res_t   w_tail_q;

  assign w_in_ent = res_capture(in_result, in_func, in_rd, in_wen);

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = out_valid & out_ready;

  // Head always holds the oldest entry; tail is only used while FULL.
  always_comb begin
    w_state_nxt = r_state;
    w_head_ld   = 1'b0;
    w_tail_ld   = 1'b0;
    w_head_d    = w_in_ent;
    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_state_nxt = ONE;
          w_head_ld   = 1'b1;
        end
      end
      ONE: begin
        if (w_push && !w_pop) begin
          w_state_nxt = FULL;
          w_tail_ld   = 1'b1;
        end else if (!w_push && w_pop) begin
          w_state_nxt = EMPTY;
        end else if (w_push && w_pop) begin
          // Head drains while the new entry replaces it in the same edge.
          w_head_ld = 1'b1;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (w_pop) begin
          w_state_nxt = ONE;
          w_head_ld   = 1'b1;
          w_head_d    = w_tail_q;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  // in_ready is registered from the next state so it stays low through reset
  // and never sees out_ready combinationally.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  alu_res_entry u_head (
    .clock   (clock),
    .n_reset (n_reset),
    .i_ld    (w_head_ld),
    .i_d     (w_head_d),
    .o_q     (w_head_q)
  );

  alu_res_entry u_tail (
    .clock   (clock),
    .n_reset (n_reset),
    .i_ld    (w_tail_ld),
    .i_d     (w_in_ent),
    .o_q     (w_tail_q)
  );

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_state != EMPTY);
  assign out_result = w_head_q.result;
  assign out_rd     = w_head_q.rd;
  assign out_wen    = w_head_q.wen;
  assign out_zero   = w_head_q.zero;
  assign out_func   = w_head_q.func;

`ifdef ALU_RES_FWD_EN
  // Youngest valid entry that writes a register wins; tail is younger.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    if ((r_state == FULL) && w_tail_q.wen) begin
      fwd_valid = 1'b1;
      fwd_rd    = w_tail_q.rd;
      fwd_data  = w_tail_q.result;
    end else if ((r_state != EMPTY) && w_head_q.wen) begin
      fwd_valid = 1'b1;
      fwd_rd    = w_head_q.rd;
      fwd_data  = w_head_q.result;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: queue model plus directed vectors.
// Latency: n/a.
// Backpressure: driven by out_ready patterns below.
module tb_alu_result_stage;

  localparam logic [3:0] FADD = 4'd1;
  localparam logic [3:0] FSUB = 4'd2;

  logic        clock;
  logic        n_reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_func;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_zero;
  logic [3:0]  out_func;
`ifdef ALU_RES_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  alu_result_stage #(.N(32), .RADDR(5)) dut (
    .clock      (clock),
    .n_reset    (n_reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_func    (in_func),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wen    (out_wen),
    .out_zero   (out_zero),
    .out_func   (out_func)
`ifdef ALU_RES_FWD_EN
    ,
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  f;
    logic [4:0]  rd;
    logic        wen;
    logic        z;
  } ent_t;

  ent_t q[$];
  bit   armed;
  int   total;
  int   bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the queue model; called once per cycle.
  task automatic compare();
    logic        exp_v;
    logic        exp_r;
    ent_t        h;
    exp_v = n_reset && (q.size() > 0);
    exp_r = n_reset && armed && (q.size() < 2);
    chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, exp_r});
    if (exp_v) begin
      h = q[0];
      chk("cyc_out_result", out_result, h.res);
      chk("cyc_out_rd", {27'd0, out_rd}, {27'd0, h.rd});
      chk("cyc_out_wen", {31'd0, out_wen}, {31'd0, h.wen});
      chk("cyc_out_zero", {31'd0, out_zero}, {31'd0, h.z});
      chk("cyc_out_func", {28'd0, out_func}, {28'd0, h.f});
    end else if (!n_reset) begin
      chk("cyc_rst_outs", {out_result, out_rd, out_wen, out_zero, out_func} == '0 ? 32'd0 : 32'd1, 32'd0);
    end
`ifdef ALU_RES_FWD_EN
    begin
      logic        fv;
      logic [4:0]  frd;
      logic [31:0] fd;
      fv = 1'b0;
      frd = '0;
      fd = '0;
      if (n_reset) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].wen) begin
            fv = 1'b1;
            frd = q[i].rd;
            fd = q[i].res;
            break;
          end
        end
      end
      chk("cyc_fwd_valid", {31'd0, fwd_valid}, {31'd0, fv});
      chk("cyc_fwd_rd", {27'd0, fwd_rd}, {27'd0, frd});
      chk("cyc_fwd_data", fwd_data, fd);
    end
`endif
  endtask

  // One clock: check at negedge, advance the model, return at posedge+1.
  task automatic tick(output bit pushed);
    bit   m_push;
    bit   m_pop;
    ent_t e;
    @(negedge clock);
    compare();
    m_push = in_valid && n_reset && armed && (q.size() < 2);
    m_pop  = n_reset && (q.size() > 0) && out_ready;
    if (m_pop) void'(q.pop_front());
    if (m_push) begin
      e.res = in_result;
      e.f   = in_func;
      e.rd  = in_rd;
      e.wen = in_wen && (in_rd != 5'd0);
      e.z   = (in_result == 32'd0);
      q.push_back(e);
    end
    pushed = m_push;
    @(posedge clock);
    #1;
    if (n_reset) armed = 1'b1;
  endtask

  task automatic send(input logic [31:0] r, input logic [3:0] f, input logic [4:0] rd, input logic w);
    bit p;
    int n;
    in_valid  = 1'b1;
    in_result = r;
    in_func   = f;
    in_rd     = rd;
    in_wen    = w;
    n = 0;
    p = 1'b0;
    while (!p && n < 40) begin
      tick(p);
      n++;
    end
    in_valid = 1'b0;
    if (!p) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=no_accept want=accept value=%0h", r);
    end
  endtask

  task automatic drain();
    bit p;
    int n;
    n = 0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 10) begin
      tick(p);
      n++;
    end
    tick(p);
  endtask

  initial begin
    bit p;
    int npush;
    total = 0;
    bad = 0;
    armed = 1'b0;
    n_reset = 1'b0;
    in_valid = 1'b0;
    in_result = '0;
    in_func = '0;
    in_rd = '0;
    in_wen = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tags", {21'd0, out_rd, out_wen, out_zero, out_func}, 32'd0);
    n_reset = 1'b1;
    tick(p);
    chk("ready_after_release", {31'd0, in_ready}, 32'd1);

    // Pass-through: 118+20
    out_ready = 1'b1;
    send(32'd138, FADD, 5'd3, 1'b1);
    chk("pt_valid", {31'd0, out_valid}, 32'd1);
    chk("pt_result", out_result, 32'd138);
    chk("pt_rd", {27'd0, out_rd}, 32'd3);
    chk("pt_wen", {31'd0, out_wen}, 32'd1);
    chk("pt_zero", {31'd0, out_zero}, 32'd0);

    // Zero flag: 8-8
    send(32'd0, FSUB, 5'd5, 1'b1);
    chk("zero_flag", {31'd0, out_zero}, 32'd1);
    chk("zero_wen", {31'd0, out_wen}, 32'd1);
    chk("zero_func", {28'd0, out_func}, {28'd0, FSUB});

    // x0 write suppression
    send(32'd40, FADD, 5'd0, 1'b1);
    chk("x0_wen", {31'd0, out_wen}, 32'd0);
    chk("x0_result", out_result, 32'd40);
    drain();

    // Backpressure: 20, 30 fill the buffer, 40 waits upstream
    out_ready = 1'b0;
    send(32'd20, FADD, 5'd1, 1'b1);
    send(32'd30, FADD, 5'd2, 1'b1);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_result = 32'd40;
    in_func = FADD;
    in_rd = 5'd4;
    in_wen = 1'b1;
    npush = 0;
    for (int i = 0; i < 3; i++) begin
      tick(p);
      if (p) npush++;
    end
    chk("bp_held_no_push", npush, 32'd0);
    chk("bp_head_stable", out_result, 32'd20);
    out_ready = 1'b1;
    tick(p);
    chk("bp_second", out_result, 32'd30);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    tick(p);
    in_valid = 1'b0;
    chk("bp_third_pushed", {31'd0, p}, 32'd1);
    chk("bp_third", out_result, 32'd40);
    drain();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Simultaneous push/pop in ONE for 5 cycles
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(32'd100 + i, FADD, 5'd9, 1'b1);
      chk("pp_value", out_result, 32'd100 + i);
      chk("pp_ready", {31'd0, in_ready}, 32'd1);
    end
    drain();

    // Fill to FULL, check forwarding, then reset mid-operation
    out_ready = 1'b0;
    send(32'h11, FADD, 5'd3, 1'b1);
    send(32'hFFFF_FFFE, FSUB, 5'd7, 1'b1);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
`ifdef ALU_RES_FWD_EN
    chk("fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("fwd_rd", {27'd0, fwd_rd}, 32'd7);
    chk("fwd_data", fwd_data, 32'hFFFF_FFFE);
`endif
    #2;
    n_reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
`ifdef ALU_RES_FWD_EN
    chk("mid_rst_fwd", {31'd0, fwd_valid}, 32'd0);
`endif
    q.delete();
    armed = 1'b0;
    out_ready = 1'b1;
    tick(p);
    tick(p);
    n_reset = 1'b1;
    tick(p);
    tick(p);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    send(32'd55, FADD, 5'd2, 1'b1);
    chk("post_rst_push", out_result, 32'd55);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-writeback buffer directly downstream of `alu`.
- Captures each ALU result with its destination register and write-enable, and derives a zero flag.
- Holds up to two entries in a skid buffer so a writeback stall never drops a result.
- Presents the oldest entry to the register-file writeback port with a valid/ready handshake.

Parameters:
- N, 32, data width; matches the ALU `n`.
- RADDR, 5, register-address width.

Ports:
- clock  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result and tags valid this cycle.
- in_ready  output  1  stage can accept an entry.
- in_result  input  N  ALU result.
- in_func  input  4  ALU function code, using the `alu_codes.sv` values.
- in_rd  input  RADDR  destination register.
- in_wen  input  1  instruction writes a register.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback consumes the head entry.
- out_result  output  N  head result.
- out_rd  output  RADDR  head destination.
- out_wen  output  1  head write-enable, already qualified.
- out_zero  output  1  head result == 0.
- out_func  output  4  head function code.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `n_reset` is asynchronous, active-low.
- Reset state: state EMPTY, both entries cleared. out_valid, out_result, out_rd, out_wen, out_zero and out_func are all 0. in_ready is held 0 while n_reset is low and becomes 1 in the first cycle after release.
- FSM states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Handshakes: push = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions:
  - EMPTY + push -> ONE.
  - ONE + push & !pop -> FULL.
  - ONE + !push & pop -> EMPTY.
  - ONE + push & pop -> ONE; the new entry becomes head in the next cycle.
  - FULL + pop -> ONE; tail moves to head.
  - FULL ignores in_valid, since in_ready=0.
- Latency: an entry pushed in cycle t is visible on out_* in cycle t+1 (registered outputs). There is no combinational path from in_* to out_*.
- in_ready depends only on state. It must not depend combinationally on out_ready.
- Capture rules:
  - out_zero is latched as (in_result == 0).
  - out_wen is latched as in_wen & (in_rd != 0); register x0 is never written.
  - in_func is stored unchanged.
- Entries hold all captured values while out_ready is low. out_* must stay stable until the entry is popped.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Arithmetic: none beyond the N-bit zero compare. Values are stored bit-exact and no sign handling is applied.

Optional Feature:
- Macro: ALU_RES_FWD_EN.
- When defined, add three outputs: fwd_valid (1), fwd_rd (RADDR), fwd_data (N).
  - The forwarding source is the youngest valid entry with out_wen qualification set (tail if FULL, else head).
  - If no such entry exists, fwd_valid=0 and fwd_rd/fwd_data=0.
  - All three outputs are combinational from registered state only.
  - All three are 0 during reset.
- When not defined, these ports and their logic do not exist. Core behaviour is identical in both builds.

Decomposition:
- Package `alu_pkg`:
  - typedef `alu_res_t` struct {result, func, rd, wen, zero};
  - state enum `res_state_t` {EMPTY, ONE, FULL};
  - localparam FUNC_W=4.
- Sub-module `alu_res_entry`: a single enable-loaded register of type `alu_res_t`. It is instantiated twice (head, tail).

Test Plan:
- Pass-through: in_valid=1 with result 138 (FADD 118+20), rd=3, wen=1, out_ready=1. Required next cycle: out_valid=1, out_result=138, out_rd=3, out_wen=1, out_zero=0.
- Zero flag: FSUB 8-8 gives result 0, rd=5. Required: out_zero=1, out_wen=1.
- x0 suppression: rd=0, wen=1, result 40. Required: out_wen=0, out_result=40.
- Backpressure: out_ready=0, push 20, 30, 40 on consecutive cycles.
  - in_ready drops to 0 after the second push and 40 is held upstream.
  - Then raise out_ready. Required output order 20, 30, 40, with out_* stable while stalled.
- Simultaneous push/pop in ONE: the state stays ONE across 5 consecutive cycles and every value appears exactly once, in order.
- Reset mid-operation: assert n_reset while FULL. Required: out_valid=0 with no clock edge, and after release out_valid stays 0 until the next push.
- Forwarding (build with ALU_RES_FWD_EN): hold FULL with head rd=3 and tail rd=7 (tail data 0xFFFFFFFE). Required: fwd_valid=1, fwd_rd=7, fwd_data=0xFFFFFFFE.
